digit_scan: RTL and testbench
=============================

DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 blanks leading zero digits; 0 shows all four digits.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = scanning runs; 0 = display dark and scan state held at digit 0.
REQ-006 load  input  1  single-cycle strobe; captures din/dp_in at this edge.
REQ-007 din  input  16  four hex digits; din[3:0] is digit 0 (rightmost).
REQ-008 dp_in  input  4  decimal point per digit; 1 = lit.
REQ-009 nibble  output  4  hex digit for the downstream 7-segment decoder.
REQ-010 an  output  4  digit select, active-low, one-hot-low while scanning.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 pending  output  1  1 = captured value not yet committed to the display.

Function
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick = (count == CLK_DIV-1) and enable.
REQ-014 The 2-bit digit index SHALL increment on tick and wrap 3->0; it holds otherwise.
REQ-015 Frame boundary = tick while index == 3.
REQ-016 load SHALL write din/dp_in into a shadow register and set pending the next cycle.
REQ-017 A load while pending=1 SHALL overwrite the shadow; the last load before commit wins.
REQ-018 At a frame boundary with pending=1, shadow SHALL copy to the active register and pending SHALL clear.
REQ-019 load coincident with a frame boundary SHALL write din/dp_in directly to active and to shadow; pending SHALL read 0 afterwards.
REQ-020 With enable=0, a load SHALL commit to active on the next cycle; there is no frame wait.
REQ-021 an, nibble and dp SHALL be registered and reflect the index value one cycle after it changes.
REQ-022 For index i, the outputs SHALL be an = ~(1<<i), nibble = active digit i, dp = ~active_dp[i].
REQ-023 With BLANK_LZ=1, digit i (i>=1) is blanked when it and all higher digits are 0 and its dp bit is 0; digit 0 is never blanked.
REQ-024 A blanked digit SHALL drive an=4'b1111 for its slot and nibble=0.
REQ-025 With enable=0, the outputs SHALL be an=4'b1111, dp=1 and nibble=0; prescaler and index are forced to 0.
REQ-026 When enable rises, scanning SHALL start at digit 0 with count=0.

Reset
REQ-027 reset SHALL override enable and load in the same cycle.
REQ-028 After reset: count=0, index=0, active=0, shadow=0, pending=0, an=4'b1111, nibble=0, dp=1.
REQ-029 Reset mid-frame SHALL discard any pending value; the first post-reset frame SHALL start at digit 0.

Structure
REQ-030 A shared package SHALL hold the constants AN_OFF=4'b1111, DIGITS=4 and the index width (2).
REQ-031 The prescaler SHALL be one sub-module, scan_tick (parameter CLK_DIV; ports clk, reset, enable, tick).
REQ-032 The output nibble SHALL feed the existing 7-segment decoder unchanged; this block SHALL NOT decode segments itself.

Verification (CLK_DIV=4)
REQ-033 Reset, enable=1, load din=16'h12AB, dp_in=0 -> after the commit, an cycles 1110,1101,1011,0111 every 4 clk with nibble B,A,2,1.
REQ-034 BLANK_LZ=1, din=16'h0050 -> digit slots 3 and 2 drive an=1111 while digits 1 and 0 show 5 and 0; with dp_in=4'b1000, digit 3 shows 0 with dp=0.
REQ-035 load 16'h1111 mid-frame, then load 16'h2222 two cycles later -> pending=1 until the next frame boundary, then every digit shows 2.
REQ-036 load in the exact frame-boundary cycle -> new value shown from digit 0 of the next frame and pending=0.
REQ-037 reset asserted mid-frame with pending=1 -> next cycle an=1111, pending=0, active=0; scanning restarts at digit 0.
REQ-038 enable=0 for 10 cycles, then enable=1 -> outputs dark while low, first an=1110 one cycle after enable rises, slot width 4 cycles.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package digit_scan_pkg;

    localparam logic [3:0] AN_OFF = 4'b1111;  // all digit selects inactive
    localparam int         DIGITS = 4;
    localparam int         IDX_W  = 2;

    typedef logic [IDX_W-1:0] idx_t;

    // One displayable value: four hex digits plus their decimal points.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dps;
    } disp_t;

    // Active-low one-hot digit select for slot idx.
    function automatic logic [3:0] an_select(idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/digit_scan_tick.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled and flags the last count.
module scan_tick
    import digit_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: wrap at the last count, park at 0 while disabled.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no path leaves it unassigned and infers a latch.
        count_d = count_q + 16'd1;
        if (!enable || count_q == LAST) begin
            count_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/digit_scan.sv
// Four-digit hex display scanner with double-buffered value, frame-aligned
// commit and optional leading-zero blanking. Drives a downstream 7-segment
// decoder with the raw nibble.
module digit_scan
    import digit_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic        pending
);

    logic        tick;
    logic        frame;
    idx_t        idx_q,     idx_d;
    disp_t       shadow_q,  shadow_d;
    disp_t       active_q,  active_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q,      an_d;
    logic [3:0]  nib_q,     nib_d;
    logic        dp_q,      dp_d;
    logic [DIGITS-1:0] blank;

    scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // A frame ends on the tick that wraps the index from the last digit.
    assign frame = tick && (idx_q == idx_t'(DIGITS - 1));

    // Digit index: advance on tick, held at digit 0 while disabled.
    always_comb begin
        idx_d = idx_q;
        if (!enable) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = idx_q + idx_t'(1);
        end
    end

    // Shadow/active buffering: loads land in shadow and are promoted at a
    // frame boundary, or immediately when the display is dark.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = '{digits: din, dps: dp_in};
            if (frame) begin
                active_d  = shadow_d;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (pending_q && (frame || !enable)) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Leading-zero blanking: digit i hides when it and every higher digit
    // are zero and its own decimal point is off; digit 0 always shows.
    always_comb begin
        blank = '0;
        if (BLANK_LZ) begin
            for (int i = 1; i < DIGITS; i++) begin
                blank[i] = !active_q.dps[i];
                for (int j = i; j < DIGITS; j++) begin
                    if (active_q.digits[4*j +: 4] != 4'd0) begin
                        blank[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Output drive for the current slot; dark when disabled or blanked.
    always_comb begin
        an_d  = AN_OFF;
        nib_d = '0;
        dp_d  = 1'b1;
        if (enable && !blank[idx_q]) begin
            an_d  = an_select(idx_q);
            nib_d = active_q.digits[{idx_q, 2'b00} +: 4];
            dp_d  = ~active_q.dps[idx_q];
        end
    end

    // State and registered outputs; reset overrides enable and load.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            nib_q     <= '0;
            dp_q      <= 1'b1;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            nib_q     <= nib_d;
            dp_q      <= dp_d;
        end
    end

    assign an      = an_q;
    assign nibble  = nib_q;
    assign dp      = dp_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan with CLK_DIV=4 and leading-zero blanking on.
module tb_digit_scan;

    typedef struct {
        logic [3:0] an;
        logic [3:0] nib;
        logic       dp;
    } slot_t;

    // Expected values are packed slot3..slot0 (slot 0 in the low bits).
    typedef struct {
        logic [15:0] din;
        logic [3:0]  dp_in;
        logic [15:0] exp_an;
        logic [15:0] exp_nib;
        logic [3:0]  exp_dp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        pending;

    int    n_vec  = 0;
    int    n_miss = 0;
    slot_t sb_q[$];
    vec_t  vecs[7];

    digit_scan #(
        .CLK_DIV  (4),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .din     (din),
        .dp_in   (dp_in),
        .nibble  (nibble),
        .an      (an),
        .dp      (dp),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_dark(input string name);
        check($sformatf("%s.an", name),  {12'h0, an},     16'h000F);
        check($sformatf("%s.nib", name), {12'h0, nibble}, 16'h0000);
        check($sformatf("%s.dp", name),  {15'h0, dp},     16'h0001);
    endtask

    task automatic push_frame(input logic [15:0] e_an, input logic [15:0] e_nib, input logic [3:0] e_dp);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{an: e_an[4*i +: 4], nib: e_nib[4*i +: 4], dp: e_dp[i]});
        end
    endtask

    task automatic pop_slot(input string name);
        slot_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got an=%b", name, an);
            return;
        end
        e = sb_q.pop_front();
        check($sformatf("%s.an", name),  {12'h0, an},     {12'h0, e.an});
        check($sformatf("%s.nib", name), {12'h0, nibble}, {12'h0, e.nib});
        check($sformatf("%s.dp", name),  {15'h0, dp},     {15'h0, e.dp});
    endtask

    // Load a value while dark, then raise enable; returns just after the
    // first enabled edge (slot 0 on the outputs, prescaler at 1).
    task automatic preload_and_start(input logic [15:0] d, input logic [3:0] p);
        enable = 1'b0;
        cycles(1);
        din = d; dp_in = p; load = 1'b1;
        cycles(1);
        load = 1'b0;
        cycles(1);
        enable = 1'b1;
        cycles(1);
    endtask

    initial begin
        vecs[0] = '{din: 16'h12AB, dp_in: 4'b0000, exp_an: 16'h7BDE, exp_nib: 16'h12AB, exp_dp: 4'b1111};
        vecs[1] = '{din: 16'h0050, dp_in: 4'b0000, exp_an: 16'hFFDE, exp_nib: 16'h0050, exp_dp: 4'b1111};
        vecs[2] = '{din: 16'h0050, dp_in: 4'b1000, exp_an: 16'h7FDE, exp_nib: 16'h0050, exp_dp: 4'b0111};
        vecs[3] = '{din: 16'h0000, dp_in: 4'b0000, exp_an: 16'hFFFE, exp_nib: 16'h0000, exp_dp: 4'b1111};
        vecs[4] = '{din: 16'h0100, dp_in: 4'b0010, exp_an: 16'hFBDE, exp_nib: 16'h0100, exp_dp: 4'b1101};
        vecs[5] = '{din: 16'hF00E, dp_in: 4'b0101, exp_an: 16'h7BDE, exp_nib: 16'hF00E, exp_dp: 4'b1010};
        vecs[6] = '{din: 16'h0000, dp_in: 4'b0100, exp_an: 16'hFBFE, exp_nib: 16'h0000, exp_dp: 4'b1011};

        // Reset wins over a simultaneous enable and load.
        reset = 1'b1; enable = 1'b1; load = 1'b1; din = 16'hFFFF; dp_in = 4'hF;
        cycles(3);
        check_dark("reset");
        check("reset.pending", {15'h0, pending}, 16'h0000);
        reset = 1'b0; enable = 1'b0; load = 1'b0;
        cycles(1);
        check("post_reset.pending", {15'h0, pending}, 16'h0000);
        check_dark("post_reset");

        // Table: load while dark (commits one cycle later), then scan a frame.
        for (int v = 0; v < 7; v++) begin
            enable = 1'b0;
            cycles(1);
            check($sformatf("v%0d.dark_an", v), {12'h0, an}, 16'h000F);
            din = vecs[v].din; dp_in = vecs[v].dp_in; load = 1'b1;
            push_frame(vecs[v].exp_an, vecs[v].exp_nib, vecs[v].exp_dp);
            cycles(1);
            load = 1'b0;
            check($sformatf("v%0d.pend_set", v), {15'h0, pending}, 16'h0001);
            cycles(1);
            check($sformatf("v%0d.pend_clr", v), {15'h0, pending}, 16'h0000);
            enable = 1'b1;
            cycles(1);
            pop_slot($sformatf("v%0d.s0", v));
            for (int k = 1; k < 4; k++) begin
                cycles(4);
                pop_slot($sformatf("v%0d.s%0d", v, k));
            end
        end

        // Two loads mid-frame: last one wins, committed at the frame boundary.
        preload_and_start(16'h9876, 4'b0000);
        cycles(4);
        din = 16'h1111; load = 1'b1;
        cycles(1);
        load = 1'b0;
        check("ovw.pend_a", {15'h0, pending}, 16'h0001);
        cycles(1);
        din = 16'h2222; load = 1'b1;
        push_frame(16'h7BDE, 16'h2222, 4'b1111);
        cycles(1);
        load = 1'b0;
        check("ovw.pend_b", {15'h0, pending}, 16'h0001);
        cycles(5);
        check("ovw.old_s3_nib", {12'h0, nibble}, 16'h0009);
        check("ovw.old_s3_an",  {12'h0, an},     16'h0007);
        check("ovw.pend_c", {15'h0, pending}, 16'h0001);
        cycles(2);
        check("ovw.pend_d", {15'h0, pending}, 16'h0001);
        cycles(1);
        check("ovw.pend_clr", {15'h0, pending}, 16'h0000);
        cycles(1);
        pop_slot("ovw.s0");
        for (int k = 1; k < 4; k++) begin
            cycles(4);
            pop_slot($sformatf("ovw.s%0d", k));
        end

        // Load exactly on the frame-boundary edge goes straight to active.
        preload_and_start(16'h3333, 4'b0000);
        cycles(14);
        din = 16'h4567; dp_in = 4'b0001; load = 1'b1;
        push_frame(16'h7BDE, 16'h4567, 4'b1110);
        cycles(1);
        load = 1'b0;
        check("fb.pending", {15'h0, pending}, 16'h0000);
        check("fb.old_s3_nib", {12'h0, nibble}, 16'h0003);
        check("fb.old_s3_an",  {12'h0, an},     16'h0007);
        cycles(1);
        pop_slot("fb.s0");
        for (int k = 1; k < 4; k++) begin
            cycles(4);
            pop_slot($sformatf("fb.s%0d", k));
        end

        // Reset mid-frame with a pending value discards everything.
        preload_and_start(16'hABCD, 4'b0000);
        cycles(2);
        din = 16'h5555; dp_in = 4'b0000; load = 1'b1;
        cycles(1);
        load = 1'b0;
        check("rst.pend_set", {15'h0, pending}, 16'h0001);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check_dark("rst.dark");
        check("rst.pending", {15'h0, pending}, 16'h0000);
        cycles(1);
        check("rst.s0_an",  {12'h0, an},     16'h000E);
        check("rst.s0_nib", {12'h0, nibble}, 16'h0000);
        check("rst.s0_dp",  {15'h0, dp},     16'h0001);
        cycles(3);
        check("rst.s0_end_an", {12'h0, an}, 16'h000E);
        cycles(1);
        check("rst.s1_blank_an", {12'h0, an}, 16'h000F);

        // Enable low for 10 cycles, then scanning restarts at digit 0.
        enable = 1'b0; din = 16'h12AB; dp_in = 4'b0000; load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            load = 1'b0;
            check_dark($sformatf("en_low%0d", i));
        end
        enable = 1'b1;
        push_frame(16'h7BDE, 16'h12AB, 4'b1111);
        cycles(1);
        pop_slot("en.s0");
        cycles(3);
        check("en.s0_end_an", {12'h0, an}, 16'h000E);
        cycles(1);
        pop_slot("en.s1");
        cycles(4);
        pop_slot("en.s2");
        cycles(4);
        pop_slot("en.s3");

        check("sb_left", 16'(sb_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
